// File: rtl/top_decoder_pkg.sv
// Shared types and constants for the registered 3-to-8 LED decoder.
// The gate enable code mirrors the G1/G2A/G2B pins of a 74x138.
package top_decoder_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    localparam logic [2:0]       EN_ACTIVE   = 3'b100;
    localparam logic [OUT_W-1:0] LED_ALL_OFF = 8'hFF;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] led_t;

endpackage

// File: rtl/top_decoder_if.sv
// Switch/enable inputs and LED bank output of the decoder.
// The master drives the switches and watches the LEDs.
interface top_decoder_if;
    import top_decoder_pkg::*;

    logic [2:0] enable;
    sel_t       switch;
    led_t       led;

    modport master (
        output enable,
        output switch,
        input  led
    );

    modport slave (
        input  enable,
        input  switch,
        output led
    );

endinterface

// File: rtl/onehot_low_decoder.sv
// Combinational select decoder producing an active-low one-hot vector.
// With en low every output bit stays high.
module onehot_low_decoder
    import top_decoder_pkg::*;
(
    input  sel_t sel_i,
    input  logic en_i,
    output led_t out_o
);

    always_comb begin
        out_o = LED_ALL_OFF;
        for (int i = 0; i < OUT_W; i++) begin
            if (en_i && (sel_i == sel_t'(i))) begin
                out_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/top_decoder_3to8.sv
// Registered 3-to-8 decoder with a 74x138-style gate and active-low LEDs.
// One cycle of latency; the LED bank is driven straight from flops.
module top_decoder_3to8
    import top_decoder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    top_decoder_if.slave  bus
);

    logic gate_open;
    led_t led_d;
    led_t led_q;

    // Only the exact G1=1, G2A=0, G2B=0 combination opens the gate.
    assign gate_open = (bus.enable == EN_ACTIVE);

    onehot_low_decoder u_dec (
        .sel_i (bus.switch),
        .en_i  (gate_open),
        .out_o (led_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= LED_ALL_OFF;
        end else begin
            led_q <= led_d;
        end
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_top_decoder_3to8.sv
// Randomized and directed checks of the registered 3-to-8 LED decoder.
// Expected LED values come from an arithmetic model of the decode rule.
module tb_top_decoder_3to8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    top_decoder_if bus ();

    top_decoder_3to8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic r, input logic [2:0] e,
                                         input logic [2:0] s);
        int v;
        if (r) return 8'hFF;
        v = 255;
        if (e == 3'b100) v = v - (1 << s);
        return v[7:0];
    endfunction

    // Apply inputs away from the edge, then check one edge later.
    task automatic step(input string tag, input logic r, input logic [2:0] e,
                        input logic [2:0] s);
        logic [7:0] exp;
        logic [7:0] got;
        logic [7:0] nz;
        @(negedge clk);
        rst        = r;
        bus.enable = e;
        bus.switch = s;
        exp = model(r, e, s);
        @(posedge clk);
        #1;
        got = bus.led;
        check_eq(tag, got, exp);
        nz = 8'($countones(~got));
        check_eq({tag, "_zeros"}, nz, 8'((!r && e == 3'b100) ? 1 : 0));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.enable = 3'b100;
        bus.switch = 3'd2;

        step("reset0", 1'b1, 3'b100, 3'd2);
        step("reset1", 1'b1, 3'b100, 3'd6);

        for (int i = 0; i < 8; i++) begin
            step("sweep", 1'b0, 3'b100, 3'(i));
        end

        for (int i = 0; i < 8; i++) begin
            step("encode", 1'b0, 3'(i), 3'd5);
        end

        step("pre_rst", 1'b0, 3'b100, 3'd3);
        step("mid_rst", 1'b1, 3'b100, 3'd3);
        step("post_rst", 1'b0, 3'b100, 3'd3);

        step("simul_a", 1'b0, 3'b011, 3'd0);
        step("simul_b", 1'b0, 3'b100, 3'd7);

        for (int i = 0; i < 40; i++) begin
            logic       r;
            logic [2:0] e;
            logic [2:0] s;
            r = ($urandom_range(0, 99) < 20);
            e = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b100;
            s = 3'($urandom);
            step("random", r, e, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_decoder_3to8.md
Name: top_decoder_3to8

Overview:
- Registered 3-to-8 line decoder with active-low outputs, modelled on a 74x138 with a 3-bit gate-enable bus.
- Drives an 8-bit LED bank: exactly one LED bit is pulled low when the gate condition holds; otherwise all bits are high.
- Sits directly behind the board switch/enable inputs; the output is a flop bank with one-cycle latency.

Parameters:
- SEL_W, 3, select width; output width is 2**SEL_W.
- EN_ACTIVE, 3'b100, the only enable code that opens the gate (G1=1, G2A=0, G2B=0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  3  gate bus; bit2 = G1 (active-high), bit1 = G2A and bit0 = G2B (active-low).
- switch  input  3  binary select code, 0..7.
- led  output  8  registered active-low decoded output.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. There is no asynchronous path.
- Reset: on a rising clk edge with rst=1, led <= 8'hFF (all off). Reset has priority over every other input.
- Normal operation: on each rising clk edge with rst=0:
  - if enable == EN_ACTIVE, led <= 8'hFF with bit[switch] cleared to 0;
  - else led <= 8'hFF.
- Only the exact code 3'b100 enables. Every other code (000, 001, 010, 011, 101, 110, 111) forces 8'hFF.
- Formula: led_next = 8'hFF - ((1 << switch) & {8{enable==3'b100}}). This is equivalent to clearing one bit; there is no borrow or wrap.
- Latency: exactly one clock from input change to led change. Inputs are sampled only at the rising edge; led is glitch-free because it comes straight from a flop.
- Exactly one zero bit when enabled; zero zero bits when disabled or in reset. led never has two or more low bits.
- Reset mid-operation: the next edge with rst=1 drives 8'hFF regardless of enable/switch. The first edge after rst falls resumes decoding from the then-current inputs; no other state is held.
- Simultaneous changes of enable and switch take effect together on the same edge.
- No internal state besides the 8-bit output register; no FSM.

Decomposition:
- Shared package top_decoder_pkg:
  - localparam SEL_W = 3, OUT_W = 8;
  - EN_ACTIVE = 3'b100;
  - LED_ALL_OFF = 8'hFF;
  - a typedef for the 3-bit select and one for the 8-bit LED vector.
- One natural sub-module, onehot_low_decoder: purely combinational, taking sel and en, producing an active-low one-hot vector.
- The top instantiates onehot_low_decoder and adds the gate compare plus the synchronous-reset output register.

Test Plan:
- rst=1 held for 2 edges, any enable/switch -> led=8'hFF after the first edge and stays 8'hFF.
- rst=0, enable=3'b100, sweep switch 0..7 one value per cycle -> led is FE, FD, FB, F7, EF, DF, BF, 7F, each one edge after its switch value.
- rst=0, switch=3'd5, enable cycled through all 8 codes -> led=8'hDF only for enable=3'b100; 8'hFF for every other code.
- Enabled with switch=3 (led=8'hF7), then rst=1 for one edge, then rst=0 -> led goes 8'hFF on the reset edge, back to 8'hF7 on the next edge.
- Enable and switch both change on the same cycle (enable 011->100, switch 0->7) -> led goes 8'hFF -> 8'h7F one edge later, with no intermediate value.
- Random 40-cycle run: switch random, enable mostly 3'b100 with occasional random codes, rst asserted about 20% of cycles -> led matches the formula-based model every cycle.
